// File: rtl/tb_stim_pkg.sv
// tb_stim_pkg: replay states, LFSR tap mask and count-width helper for tb_stim_driver
package tb_stim_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP, S_FINISH} state_e;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/tb_lfsr16.sv
// tb_lfsr16: 16-bit Fibonacci LFSR that steps on enable and reloads its seed on reset or load
module tb_lfsr16 import tb_stim_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);
  // shift left, feeding back the parity of the tapped bits
  always_ff @(posedge clk)
    if (rst || load_i) state_o <= seed_i;
    else if (en_i) state_o <= {state_o[14:0], ^(state_o & LFSR_TAPS)};
endmodule

// File: rtl/tb_stim_driver.sv
// tb_stim_driver: buffered valid/ready stimulus replay with inter-transfer gaps; TB_STIM_DRIVER_RAND_GAP_EN selects LFSR-random gaps
module tb_stim_driver import tb_stim_pkg::*; #(
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 16,
  parameter int          GAP    = 0,
  parameter int          GAP_W  = 3,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_valid,
  input  logic [DATA_W-1:0]         ld_data,
  output logic                      ld_ready,
  input  logic                      clear,
  input  logic                      start,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      evt,
  output logic                      busy,
  output logic                      done,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
`ifdef TB_STIM_DRIVER_RAND_GAP_EN
  localparam int GW = GAP_W;
  logic [15:0] lfsr;
  logic [GW-1:0] gap_v, gap_q;
  tb_lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (out_valid && out_ready),
    .load_i (1'b0),
    .seed_i (SEED),
    .state_o(lfsr)
  );
  assign gap_v = lfsr[GW-1:0];
`else
  localparam int GW = GAP > 1 ? $clog2(GAP + 1) : 1;
  logic [GW-1:0] gap_v, gap_q;
  assign gap_v = GW'(GAP);
`endif
  state_e              state_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [CW-1:0]       entries_q, entries_d, rd_q, rd_d;
  logic                ld_fire, last;
  assign ld_fire   = ld_valid && ld_ready && !clear;
  assign entries_d = clear ? '0 : entries_q + CW'(ld_fire);
  assign rd_d      = rd_q + CW'(1);
  assign last      = rd_q == entries_q - CW'(1);
  // vector buffer: append at the current fill level
  always_ff @(posedge clk)
    if (ld_fire) mem_q[entries_q[AW-1:0]] <= ld_data;
  // replay FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      entries_q <= '0;
      rd_q      <= '0;
      gap_q     <= '0;
      ld_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      evt       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      evt  <= 1'b0;
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          entries_q <= entries_d;
          ld_ready  <= entries_d != CW'(DEPTH);
          if (start) begin
            rd_q     <= '0;
            count    <= '0;
            ld_ready <= 1'b0;
            if (entries_d == '0) begin
              state_q <= S_FINISH;
              done    <= 1'b1;
            end else begin
              state_q   <= S_DRIVE;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              out_data  <= entries_q == '0 ? ld_data : mem_q[0];
            end
          end
        end
        S_DRIVE: if (out_ready) begin
          evt   <= 1'b1;
          count <= count + CW'(1);
          rd_q  <= rd_d;
          if (last) begin
            state_q   <= S_FINISH;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (gap_v != '0) begin
            state_q   <= S_GAP;
            out_valid <= 1'b0;
            gap_q     <= gap_v - GW'(1);
          end else out_data <= mem_q[rd_d[AW-1:0]];
        end
        S_GAP: if (gap_q == '0) begin
          state_q   <= S_DRIVE;
          out_valid <= 1'b1;
          out_data  <= mem_q[rd_q[AW-1:0]];
        end else gap_q <= gap_q - GW'(1);
        S_FINISH: begin
          state_q  <= S_IDLE;
          ld_ready <= entries_q != CW'(DEPTH);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tb_stim_driver.sv
// tb_tb_stim_driver: directed self-checking bench for tb_stim_driver
module tb_tb_stim_driver;
  logic        clk = 0, rst = 1, ld_valid = 0, clear = 0, start = 0, out_ready = 1;
  logic        g_ld_valid = 0, g_start = 0;
  logic [31:0] ld_data = '0;
  logic        ld_ready, out_valid, evt, busy, done;
  logic [31:0] out_data;
  logic [2:0]  count;
  logic        g_ld_ready, g_out_valid, g_evt, g_busy, g_done;
  logic [31:0] g_out_data;
  logic [2:0]  g_count;
  int          n_chk = 0, n_pass = 0, evt_tot = 0, snap;
  logic [31:0] a [3] = '{32'hA0, 32'hA1, 32'hA2};
  logic [31:0] c [4] = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};

  tb_stim_driver #(.DATA_W(32), .DEPTH(4), .GAP(0)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .clear(clear), .start(start), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .evt(evt), .busy(busy), .done(done), .count(count));

  tb_stim_driver #(.DATA_W(32), .DEPTH(4), .GAP(2)) dut_g (
    .clk(clk), .rst(rst), .ld_valid(g_ld_valid), .ld_data(ld_data), .ld_ready(g_ld_ready),
    .clear(clear), .start(g_start), .out_valid(g_out_valid), .out_data(g_out_data),
    .out_ready(out_ready), .evt(g_evt), .busy(g_busy), .done(g_done), .count(g_count));

  always #5 clk = ~clk;

  always @(negedge clk) if (evt) evt_tot++;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load3();
    ld_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ld_data = a[i];
      tick();
    end
    ld_valid = 0;
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_evt", evt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ld_ready", ld_ready, 1);
`ifdef TB_STIM_DRIVER_RAND_GAP_EN
    begin
      logic [15:0] r;
      int low, exp;
      r = 16'hACE1;
      ld_valid = 1;
      for (int i = 0; i < 4; i++) begin
        ld_data = c[i];
        tick();
      end
      ld_valid = 0;
      for (int p = 0; p < 2; p++) begin
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 4; k++) begin
          exp = int'(r[2:0]);
          r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
          tick();
          if (k < 3) begin
            low = 0;
            while (!out_valid && low < 16) begin
              low++;
              tick();
            end
            chk("rand_gap", low, exp);
          end
        end
        chk("rand_done", done, 1);
        tick();
      end
    end
`else
    load3();
    chk("t1_ld_ready", ld_ready, 1);
    start = 1;
    tick();
    start = 0;
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, a[i]);
      chk("t1_evt", evt, i > 0);
      tick();
    end
    chk("t1_last_evt", evt, 1);
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_valid_end", out_valid, 0);
    chk("t1_count", count, 3);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_ready", ld_ready, 1);

    snap = evt_tot;
    start = 1;
    tick();
    start = 0;
    chk("t2_a0", out_data, a[0]);
    tick();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_data", out_data, a[1]);
    end
    out_ready = 1;
    tick();
    chk("t2_a2", out_data, a[2]);
    tick();
    chk("t2_done", done, 1);
    chk("t2_count", count, 3);
    tick();
    chk("t2_evts", evt_tot - snap, 3);

    begin
      logic exp_v [5] = '{1, 0, 0, 1, 0};
      logic exp_d [5] = '{0, 0, 0, 0, 1};
      g_ld_valid = 1;
      ld_data = 32'hB0;
      tick();
      ld_data = 32'hB1;
      tick();
      g_ld_valid = 0;
      g_start = 1;
      tick();
      g_start = 0;
      chk("t3_b0", g_out_data, 32'hB0);
      for (int i = 0; i < 5; i++) begin
        chk("t3_gap_valid", g_out_valid, exp_v[i]);
        chk("t3_gap_done", g_done, exp_d[i]);
        if (i == 3) chk("t3_b1", g_out_data, 32'hB1);
        tick();
      end
      chk("t3_count", g_count, 2);
    end

    clear = 1;
    tick();
    clear = 0;
    ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ld_data = c[i];
      tick();
    end
    chk("t4_full", ld_ready, 0);
    ld_data = 32'hDEAD;
    tick();
    ld_valid = 0;
    chk("t4_full_drop", ld_ready, 0);
    snap = evt_tot;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_data", out_data, c[i]);
      tick();
    end
    chk("t4_done", done, 1);
    chk("t4_count", count, 4);
    tick();
    chk("t4_evts", evt_tot - snap, 4);
    chk("t4_still_full", ld_ready, 0);

    clear = 1;
    tick();
    ld_valid = 1;
    ld_data = 32'h55;
    tick();
    clear = 0;
    ld_valid = 0;
    start = 1;
    tick();
    start = 0;
    chk("t5_empty_valid", out_valid, 0);
    chk("t5_empty_done", done, 1);
    chk("t5_empty_busy", busy, 0);
    tick();
    load3();
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("t5_mid_count", count, 2);
    chk("t5_mid_valid", out_valid, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_ready", ld_ready, 1);
    chk("t5_rst_busy", busy, 0);
    start = 1;
    tick();
    start = 0;
    chk("t5_emptied", done, 1);
    tick();

    ld_valid = 1;
    ld_data = 32'hE7;
    start = 1;
    tick();
    ld_valid = 0;
    start = 0;
    chk("t6_ld_start_valid", out_valid, 1);
    chk("t6_ld_start_data", out_data, 32'hE7);
    tick();
    chk("t6_ld_start_done", done, 1);
    chk("t6_ld_start_count", count, 1);
    tick();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tb_stim_driver.md
# tb_stim_driver

Simulation-library stimulus driver: the transmitting side that pairs with the coverage monitor. Vectors are loaded into an internal buffer and replayed onto a DUT input over a valid/ready handshake. Optional inter-transfer gaps are inserted between vectors. Each accepted transfer produces an event pulse, so the bench can register one expected event per vector and the monitor can count coverage against it. Sits in the bench between the test sequence and the DUT, clocked alongside the monitor.

## Interface
Parameters:
- DATA_W, 32, stimulus word width
- DEPTH, 16, vector buffer entries (power of two, ≥2)
- GAP, 0, fixed idle cycles inserted after each accepted transfer
- GAP_W, 3, width of the random gap field (macro build only)
- SEED, 16'hACE1, LFSR seed (macro build only; must be nonzero)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ld_valid  in  1  load strobe
- ld_data  in  DATA_W  vector to append
- ld_ready  out  1  high in IDLE when the buffer is not full
- clear  in  1  empty the buffer (IDLE only)
- start  in  1  begin replay (IDLE only)
- out_valid  out  1  stimulus valid
- out_data  out  DATA_W  stimulus word
- out_ready  in  1  DUT accepts
- evt  out  1  one-cycle pulse per accepted transfer
- busy  out  1  replay in progress
- done  out  1  one-cycle pulse at end of replay
- count  out  $clog2(DEPTH+1)  transfers accepted in the current replay

## Operation
- States are IDLE, DRIVE, GAP and FINISH.
- IDLE:
  - ld_valid&&ld_ready writes ld_data at index `entries`, then entries++.
  - clear sets entries=0. clear takes priority over a simultaneous load.
  - start moves to DRIVE with rd_idx=0 and count=0. If entries==0, start goes to FINISH instead.
  - start together with ld_valid in the same cycle: the load is taken first, then the replay includes that vector.
- DRIVE:
  - out_valid=1, out_data=buf[rd_idx].
  - On out_valid&&out_ready: evt=1, count++, rd_idx++.
  - If rd_idx was entries-1, go to FINISH.
  - Otherwise, if gap>0 go to GAP; if gap==0 stay in DRIVE.
- GAP: out_valid=0. Down-counts the gap, then returns to DRIVE.
- FINISH: done=1 for one cycle, then IDLE.
- The buffer persists across replays. A second start replays the same vectors.
- In non-IDLE states, ld_valid, clear and start are ignored, and ld_ready=0.
- Handshake rule: while out_valid&&!out_ready, out_valid and out_data hold stable. The driver never withdraws valid.
- rd_idx does not wrap. Replay ends at entries-1.
- Arithmetic: count saturates at DEPTH by construction. entries is $clog2(DEPTH+1) bits wide.

## Timing
- Reset values:
  - out_valid=0, out_data=0, evt=0, busy=0, done=0, count=0.
  - ld_ready=1, entries=0, state IDLE, LFSR=SEED.
- start at cycle t: out_valid=1 with buf[0] at t+1. busy=1 from t+1.
- With gap==0 and out_ready held high, transfers are back-to-back, one per cycle.
- With gap G, out_valid is low for exactly G cycles after each accepted transfer except the last.
- Last accept at cycle t: done=1 at t+1, busy=0 at t+1, IDLE at t+2.
- evt is registered and asserts in the cycle after the accepting handshake.
- Mid-operation rst: all outputs take reset values on the next edge, and the buffer is emptied.

## Configuration
- TB_STIM_DRIVER_RAND_GAP_EN defined:
  - The gap per transfer is lfsr[GAP_W-1:0], giving 0..2^GAP_W-1 cycles.
  - The 16-bit Fibonacci LFSR advances once per accepted transfer.
  - The GAP parameter is ignored.
- Undefined: the gap is the constant GAP, and no LFSR logic is present.

## Structure
- Package tb_stim_pkg holds:
  - the state enum (IDLE, DRIVE, GAP, FINISH);
  - the LFSR tap constant (16'hB400);
  - the localparam helper for count width.
- One sub-module, tb_lfsr16 (enable, seed load, 16-bit state out), instantiated only under the macro.

## Test plan
- Load 3 words (A0, A1, A2), GAP=0, out_ready=1, start at t → out_data A0/A1/A2 at t+1..t+3; evt at t+2..t+4; done at t+4; count=3.
- Same 3 words, out_ready low for 4 cycles on A1 → out_data=A1 held stable with valid high; total 3 evt; count=3.
- GAP=2 with 2 words → exactly 2 cycles of out_valid=0 between A0 accept and A1 valid; none after A1.
- Load DEPTH words → ld_ready=0. A further ld_valid is dropped, and replay yields exactly DEPTH transfers.
- start with entries=0 → no out_valid, done at t+1. Then rst asserted mid-DRIVE after 2 accepts → next cycle out_valid=0, count=0, ld_ready=1.
- Macro build, SEED=16'hACE1, GAP_W=3 → observed gaps match a bench-side reference LFSR sequence over 8 transfers.
